// File: rtl/delay_line_pkg.sv
// delay_line_pkg: shared helpers and update-mode encoding for the delay line
package delay_line_pkg;
  typedef enum logic [2:0] {
    UPD_RESET,
    UPD_DEPTH_CHG,
    UPD_FLUSH,
    UPD_SHIFT,
    UPD_HOLD
  } upd_mode_e;
  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/delay_stage.sv
// delay_stage: one data+valid register of the delay line
module delay_stage #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift,
  input  logic             clr_vld,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);
  always_ff @(posedge clock) begin
    if (reset) begin
      q     <= RESET_VALUE;
      q_vld <= 1'b0;
    end else if (clr_vld) begin
      q_vld <= 1'b0;
    end else if (shift) begin
      q     <= d;
      q_vld <= d_vld;
    end
  end
endmodule

// File: rtl/delay_line_param.sv
// delay_line_param: valid-qualified delay line with runtime-selectable depth
module delay_line_param
  import delay_line_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MAX_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int SEL_W = clog2_min1(MAX_DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic [SEL_W-1:0] delay_sel,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             primed
);
  localparam int FW = $clog2(MAX_DEPTH + 1);
  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_DEPTH - 1);
  logic [SEL_W-1:0] cur_sel, sel_req;
  logic [FW-1:0] fill_cnt, fill_nxt, depth, depth_nxt;
  upd_mode_e mode;
  logic shift, clr_vld;
  logic [WIDTH-1:0] data [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] vld;
  always_comb begin
    sel_req   = (delay_sel > MAX_SEL) ? MAX_SEL : delay_sel;
    mode      = reset ? UPD_RESET
              : (sel_req != cur_sel) ? UPD_DEPTH_CHG
              : flush ? UPD_FLUSH
              : enable ? UPD_SHIFT : UPD_HOLD;
    shift     = (mode == UPD_SHIFT);
    clr_vld   = (mode == UPD_DEPTH_CHG) || (mode == UPD_FLUSH);
    depth     = FW'(cur_sel) + FW'(1);
    depth_nxt = FW'(sel_req) + FW'(1);
    fill_nxt  = shift ? ((fill_cnt == depth) ? fill_cnt : fill_cnt + FW'(1))
              : (mode == UPD_HOLD) ? fill_cnt : '0;
  end
  // sel_req equals cur_sel in every mode except reset and depth change, so it can always load
  always_ff @(posedge clock) begin
    cur_sel  <= sel_req;
    fill_cnt <= fill_nxt;
    primed   <= (fill_nxt == depth_nxt);
  end
  for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      delay_stage #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_stage (
        .clock(clock), .reset(reset), .shift(shift), .clr_vld(clr_vld),
        .d(in), .d_vld(in_valid), .q(data[k]), .q_vld(vld[k])
      );
    end else begin : g_body
      delay_stage #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_stage (
        .clock(clock), .reset(reset), .shift(shift), .clr_vld(clr_vld),
        .d(data[k-1]), .d_vld(vld[k-1]), .q(data[k]), .q_vld(vld[k])
      );
    end
  end
  assign out       = data[cur_sel];
  assign out_valid = vld[cur_sel];
endmodule
